// File: rtl/apple_placer_if.sv
// apple_placer_if: bundle between the game-step logic / random generator
// (master side) and the apple placer (slave side).
//   tick_i         game-step strobe
//   head_x_i/y_i   snake head top-left pixel
//   rand_strobe_i  fresh candidate on pos_x_rand_i/pos_y_rand_i
//   x_apple_o/y_o  current apple top-left
//   apple_valid_o  apple drawable
//   eaten_o        one-cycle pulse per apple eaten
//   score_o        apples eaten, saturating
//   velocity_o     speed level fed back to the generator
interface apple_placer_if;
    logic       tick_i;
    logic [9:0] head_x_i;
    logic [9:0] head_y_i;
    logic       rand_strobe_i;
    logic [9:0] pos_x_rand_i;
    logic [9:0] pos_y_rand_i;
    logic [9:0] x_apple_o;
    logic [9:0] y_apple_o;
    logic       apple_valid_o;
    logic       eaten_o;
    logic [7:0] score_o;
    logic [7:0] velocity_o;

    modport master (
        output tick_i, head_x_i, head_y_i, rand_strobe_i, pos_x_rand_i, pos_y_rand_i,
        input  x_apple_o, y_apple_o, apple_valid_o, eaten_o, score_o, velocity_o
    );

    modport slave (
        input  tick_i, head_x_i, head_y_i, rand_strobe_i, pos_x_rand_i, pos_y_rand_i,
        output x_apple_o, y_apple_o, apple_valid_o, eaten_o, score_o, velocity_o
    );
endinterface

// File: rtl/apple_placer.sv
// apple_placer: apple lifecycle controller for the snake game.
// Detects the head eating the apple, then collects random candidates until one
// lies inside the playfield and away from the head (or falls back to a fixed
// spot after MAX_TRIES rejects). Keeps score and the velocity level.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    apple_placer_if.slave (all handshake / coordinate / status signals)
module apple_placer #(
    parameter int unsigned APPLE_SIZE = 10,
    parameter int unsigned MAX_TRIES  = 8,
    parameter int unsigned INIT_X     = 320,
    parameter int unsigned INIT_Y     = 400,
    parameter int unsigned FALLBACK_X = 320,
    parameter int unsigned FALLBACK_Y = 60,
    parameter int unsigned SCORE_STEP = 5,
    parameter int unsigned VEL_MAX    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    apple_placer_if.slave  bus
);
    localparam int unsigned TRIES_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam int unsigned STEP_W  = (SCORE_STEP > 1) ? $clog2(SCORE_STEP) : 1;

    localparam logic [9:0]         SIZE_C     = 10'(APPLE_SIZE);
    localparam logic [9:0]         SIZE2_C    = 10'(2 * APPLE_SIZE);
    localparam logic [9:0]         EDGE_MIN_C = 10'd11;
    localparam logic [9:0]         X_MAX_C    = 10'(629 - APPLE_SIZE);
    localparam logic [9:0]         Y_MAX_C    = 10'(469 - APPLE_SIZE);
    localparam logic [TRIES_W-1:0] TRY_LAST_C = TRIES_W'(MAX_TRIES - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST_C = STEP_W'(SCORE_STEP - 1);
    localparam logic [7:0]         VEL_MAX_C  = 8'(VEL_MAX);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_WAIT   = 2'd1,
        ST_CHECK  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [9:0]          x_apple_q, x_apple_d;
    logic [9:0]          y_apple_q, y_apple_d;
    logic [9:0]          cand_x_q, cand_x_d;
    logic [9:0]          cand_y_q, cand_y_d;
    logic                valid_q, valid_d;
    logic                eaten_q, eaten_d;
    logic [7:0]          score_q, score_d;
    logic [7:0]          vel_q, vel_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [TRIES_W-1:0]  tries_q, tries_d;
    logic                hit_s;
    logic                reject_s;

    // Larger-minus-smaller so the difference never wraps.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic near(input logic [9:0] ax, input logic [9:0] ay,
                                  input logic [9:0] bx, input logic [9:0] by,
                                  input logic [9:0] thr);
        return (abs_diff(ax, bx) < thr) && (abs_diff(ay, by) < thr);
    endfunction

    assign hit_s    = near(bus.head_x_i, bus.head_y_i, x_apple_q, y_apple_q, SIZE_C);
    assign reject_s = (cand_x_q < EDGE_MIN_C) || (cand_x_q > X_MAX_C) ||
                      (cand_y_q < EDGE_MIN_C) || (cand_y_q > Y_MAX_C) ||
                      near(bus.head_x_i, bus.head_y_i, cand_x_q, cand_y_q, SIZE2_C);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: begin
                if (bus.tick_i && hit_s) state_d = ST_WAIT;
                else                     state_d = ST_ACTIVE;
            end
            ST_WAIT: begin
                if (bus.rand_strobe_i) state_d = ST_CHECK;
                else                   state_d = ST_WAIT;
            end
            ST_CHECK: begin
                if (reject_s && (tries_q != TRY_LAST_C)) state_d = ST_WAIT;
                else                                     state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // Datapath next values for every registered output and counter.
    always_comb begin
        x_apple_d = x_apple_q;
        y_apple_d = y_apple_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        valid_d   = valid_q;
        eaten_d   = 1'b0;
        score_d   = score_q;
        vel_d     = vel_q;
        step_d    = step_q;
        tries_d   = tries_q;
        case (state_q)
            ST_ACTIVE: begin
                // rand_strobe is deliberately ignored here.
                if (bus.tick_i && hit_s) begin
                    eaten_d = 1'b1;
                    valid_d = 1'b0;
                    tries_d = '0;
                    score_d = (score_q == 8'd255) ? score_q : (score_q + 8'd1);
                    if (step_q == STEP_LAST_C) begin
                        step_d = '0;
                        vel_d  = (vel_q >= VEL_MAX_C) ? vel_q : (vel_q + 8'd1);
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end else begin
                    eaten_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (bus.rand_strobe_i) begin
                    cand_x_d = bus.pos_x_rand_i;
                    cand_y_d = bus.pos_y_rand_i;
                end else begin
                    cand_x_d = cand_x_q;
                end
            end
            ST_CHECK: begin
                if (!reject_s) begin
                    x_apple_d = cand_x_q;
                    y_apple_d = cand_y_q;
                    valid_d   = 1'b1;
                end else if (tries_q == TRY_LAST_C) begin
                    x_apple_d = 10'(FALLBACK_X);
                    y_apple_d = 10'(FALLBACK_Y);
                    valid_d   = 1'b1;
                end else begin
                    tries_d = tries_q + TRIES_W'(1);
                end
            end
            default: begin
                valid_d = valid_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_apple_q <= 10'(INIT_X);
            y_apple_q <= 10'(INIT_Y);
            cand_x_q  <= 10'd0;
            cand_y_q  <= 10'd0;
            valid_q   <= 1'b1;
            eaten_q   <= 1'b0;
            score_q   <= 8'd0;
            vel_q     <= 8'd1;
            step_q    <= '0;
            tries_q   <= '0;
        end else begin
            x_apple_q <= x_apple_d;
            y_apple_q <= y_apple_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            valid_q   <= valid_d;
            eaten_q   <= eaten_d;
            score_q   <= score_d;
            vel_q     <= vel_d;
            step_q    <= step_d;
            tries_q   <= tries_d;
        end
    end

    assign bus.x_apple_o     = x_apple_q;
    assign bus.y_apple_o     = y_apple_q;
    assign bus.apple_valid_o = valid_q;
    assign bus.eaten_o       = eaten_q;
    assign bus.score_o       = score_q;
    assign bus.velocity_o    = vel_q;
endmodule

// File: doc/apple_placer.md
# apple_placer

Apple lifecycle controller for the snake game; consumes the random candidate coordinates produced by the position generator. It detects the snake head eating the apple and then requests, screens and latches a new apple position. It also maintains the score and the velocity level, and feeds velocity back to the generator. It sits between the game-step logic, the random generator and the renderer.

## Interface
- APPLE_SIZE, 10: apple/head square edge in pixels.
- MAX_TRIES, 8: rejected candidates before fallback placement.
- INIT_X, 320 / INIT_Y, 400: apple position after reset.
- FALLBACK_X, 320 / FALLBACK_Y, 60: position used when tries are exhausted.
- SCORE_STEP, 5: apples eaten per velocity increment.
- VEL_MAX, 8: velocity ceiling.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- tick  in  1  one-cycle game-step strobe.
- head_x, head_y  in  10 each  snake head top-left pixel.
- rand_strobe  in  1  one-cycle pulse: pos_x_rand/pos_y_rand hold a fresh candidate.
- pos_x_rand, pos_y_rand  in  10 each  candidate from the generator.
- x_apple, y_apple  out  10 each  current apple top-left, registered.
- apple_valid  out  1  apple placed and drawable.
- eaten  out  1  one-cycle pulse per apple eaten.
- score  out  8  apples eaten, saturates at 255.
- velocity  out  8  speed level, 1..VEL_MAX; drives the generator velocity input.

## Operation
- States: ACTIVE, WAIT, CHECK. Reset enters ACTIVE.
- Hit condition: |head_x−x_apple| < APPLE_SIZE and |head_y−y_apple| < APPLE_SIZE. Use unsigned compares on the larger-minus-smaller difference; no wrap.
- ACTIVE: if tick and hit, then:
  - score += 1, saturating at 255.
  - eaten = 1 for one cycle.
  - apple_valid = 0.
  - tries = 0.
  - step_cnt += 1. On reaching SCORE_STEP, step_cnt = 0 and velocity += 1, saturating at VEL_MAX.
  - Go to WAIT.
  - tick without a hit does nothing. rand_strobe is ignored.
- WAIT: on rand_strobe, latch cand_x/cand_y from pos_*_rand and go to CHECK. tick is ignored.
- CHECK: reject the candidate if any of the following holds:
  - cand_x < 11 or cand_x > 629−APPLE_SIZE;
  - cand_y < 11 or cand_y > 469−APPLE_SIZE;
  - cand overlaps the head, using the hit rule with threshold 2·APPLE_SIZE.
- CHECK outcomes:
  - Accept: x_apple/y_apple = cand, apple_valid = 1, go to ACTIVE.
  - Reject with tries == MAX_TRIES−1: x_apple/y_apple = FALLBACK, apple_valid = 1, go to ACTIVE.
  - Other reject: tries += 1, go to WAIT.
- tries counter is $clog2(MAX_TRIES) wide.
- A rand_strobe arriving in CHECK is dropped; only WAIT samples candidates.
- x_apple/y_apple change only on the CHECK→ACTIVE transition or on reset.

## Timing
- Reset values:
  - x_apple=INIT_X, y_apple=INIT_Y;
  - apple_valid=1, eaten=0;
  - score=0, velocity=1;
  - step_cnt=0, tries=0;
  - state ACTIVE.
- Reset asserted mid-search aborts immediately to the reset values. No eaten pulse is generated.
- Hit sampled at edge T: eaten and apple_valid=0 visible after T; state WAIT.
- Earliest rand_strobe sampled at edge T+1 → CHECK. Edge T+2 → ACTIVE with the new apple and apple_valid=1. Minimum re-placement latency is 2 cycles after the hit edge.
- Each rejected candidate costs 1 cycle plus the wait for the next rand_strobe.
- score and velocity update at the hit edge, concurrently with eaten.
- tick and rand_strobe both high while in ACTIVE: only tick is evaluated.

## Test plan
- Reset then idle: outputs are (320,400), valid=1, score=0, velocity=1. tick with head=(100,100) → no change.
- head=(325,405), tick → eaten pulse, score=1, valid=0. Strobe with (200,200) → next cycle apple=(200,200), valid=1.
- After a hit, strobe (5,200) then (300,475) → both rejected, valid stays 0. Strobe (50,50) → apple=(50,50) on the third candidate.
- After a hit, 8 strobes of out-of-range (0,0) → apple=(320,60), valid=1 after the 8th CHECK.
- 5 consecutive eats → velocity=2 on the 5th eaten pulse. 40 eats → velocity saturates at 8. 300 eats → score=255.
- Assert reset while in WAIT → immediate return to (320,400), valid=1, score=0. A later strobe is ignored until the next hit.
